// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmit register.
// Serial word length depends on the optional PISO_PARITY_EN build macro.
package piso_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } piso_state_e;

  localparam int unsigned PisoDefaultWidth = 4;

  // Serial bits per word: the data bits plus one trailing parity bit when enabled.
  function automatic int unsigned piso_bits(input int unsigned n, input bit parity_en);
    return parity_en ? n + 1 : n;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the serial transmitter: synchronous clear, enable-increment,
// and a flag raised while the final bit of a word is on the line.
module piso_bit_counter #(
  parameter int unsigned Bits = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CntW = $clog2(Bits + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == CntW'(Bits - 1));

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out transmit register, LSB first, valid/ready load side.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int unsigned N = PisoDefaultWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  input  logic         shift_en,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

`ifdef PISO_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam int unsigned Bits = piso_bits(N, ParityEn);

  piso_state_e state_q;
  logic [N-1:0] sr_q;
  logic         ready_q;
  logic         done_q;
  logic         cnt_last;
  logic         handshake;
  logic         shift_step;
  logic         line_bit;

  assign handshake  = load_valid & ready_q;
  assign shift_step = (state_q == StShift) & shift_en;

  piso_bit_counter #(
    .Bits (Bits)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (handshake),
    .en   (shift_step),
    .last (cnt_last)
  );

  // ready is registered so it stays low through reset and rises the cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (handshake) begin
            sr_q    <= load_data;
            state_q <= StShift;
            ready_q <= 1'b0;
          end
        end
        StShift: begin
          if (shift_en) begin
            sr_q <= sr_q >> 1;
            if (cnt_last) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (handshake) begin
      par_q <= ^load_data;
    end
  end

  // With parity, the final counted bit is the parity bit rather than shift-register data.
  assign line_bit = cnt_last ? par_q : sr_q[0];
`else
  assign line_bit = sr_q[0];
`endif

  assign load_ready = ready_q;
  assign sout_valid = (state_q == StShift);
  assign busy       = (state_q == StShift);
  assign sout       = (state_q == StShift) & line_bit;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: serial bits are scoreboarded when a
// word is offered and compared by a monitor as the DUT puts them on the line.
module tb_piso_shift_reg;

`ifdef PISO_PARITY_EN
  localparam int Bits = 5;
`else
  localparam int Bits = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       shift_en = 1'b0;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic exp_q[$];

  piso_shift_reg #(
    .N (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  // Line monitor: every valid cycle must match the head of the scoreboard;
  // the head is retired only when the sink consumes the bit.
  always @(negedge clk) begin
    if (!rst && sout_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_bit", {31'b0, sout_valid}, 32'd0);
      end else begin
        check_eq("sout_bit", {31'b0, sout}, {31'b0, exp_q[0]});
        if (shift_en) void'(exp_q.pop_front());
      end
    end
  end

  // Offer one word, run it out with an optional stall, and check done timing.
  task automatic send(input logic [3:0] w, input int stall_at, input int stall_len);
    push_word(w);
    load_valid = 1'b1;
    load_data  = w;
    shift_en   = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = ~w;
    check_eq("first_valid", {31'b0, sout_valid}, 32'd1);
    check_eq("busy_shift", {31'b0, busy}, 32'd1);
    check_eq("ready_shift", {31'b0, load_ready}, 32'd0);
    for (int i = 0; i < Bits; i++) begin
      if (i == stall_at) begin
        shift_en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check_eq("stall_valid", {31'b0, sout_valid}, 32'd1);
          check_eq("stall_done", {31'b0, done}, 32'd0);
        end
        shift_en = 1'b1;
      end
      check_eq("mid_done", {31'b0, done}, 32'd0);
      tick();
    end
    check_eq("done_pulse", {31'b0, done}, 32'd1);
    check_eq("done_ready", {31'b0, load_ready}, 32'd1);
    check_eq("done_valid", {31'b0, sout_valid}, 32'd0);
    check_eq("sb_drained", exp_q.size(), 32'd0);
    tick();
    check_eq("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_ready", {31'b0, load_ready}, 32'd0);
    check_eq("rst_valid", {31'b0, sout_valid}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_sout", {31'b0, sout}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rel_ready", {31'b0, load_ready}, 32'd1);

    // shift_en in IDLE is ignored
    shift_en = 1'b1;
    tick();
    check_eq("idle_valid", {31'b0, sout_valid}, 32'd0);

    // Plain word, then same word stalled on bit 1 for two cycles
    send(4'b1011, -1, 0);
    send(4'b1011, 1, 2);
    send(4'b0011, -1, 0);
    send(4'b0110, 0, 1);

    // load_valid held high across two words
    push_word(4'hA);
    load_valid = 1'b1;
    load_data  = 4'hA;
    shift_en   = 1'b1;
    tick();
    push_word(4'h5);
    load_data = 4'h5;
    for (int i = 0; i < Bits; i++) begin
      check_eq("b2b_ready_low", {31'b0, load_ready}, 32'd0);
      tick();
    end
    check_eq("b2b_done", {31'b0, done}, 32'd1);
    check_eq("b2b_gap", {31'b0, sout_valid}, 32'd0);
    check_eq("b2b_ready", {31'b0, load_ready}, 32'd1);
    tick();
    load_valid = 1'b0;
    check_eq("b2b_second_valid", {31'b0, sout_valid}, 32'd1);
    for (int i = 0; i < Bits; i++) tick();
    check_eq("b2b_done2", {31'b0, done}, 32'd1);
    check_eq("b2b_drained", exp_q.size(), 32'd0);
    tick();

    // Reset on the third serial bit aborts the word
    push_word(4'b1101);
    load_valid = 1'b1;
    load_data  = 4'b1101;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    check_eq("abort_valid", {31'b0, sout_valid}, 32'd0);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("abort_ready", {31'b0, load_ready}, 32'd1);
    for (int i = 0; i < Bits; i++) begin
      check_eq("abort_no_done", {31'b0, done}, 32'd0);
      tick();
    end

    // Handshake on the same edge as reset is dropped
    load_valid = 1'b1;
    load_data  = 4'hF;
    rst        = 1'b1;
    tick();
    load_valid = 1'b0;
    rst        = 1'b0;
    for (int i = 0; i < Bits + 2; i++) begin
      check_eq("rst_hs_valid", {31'b0, sout_valid}, 32'd0);
      tick();
    end

    // Word after all that still goes through cleanly
    send(4'b1001, 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in serial-out transmit register: accepts an N-bit word through a valid/ready load handshake and shifts it out one bit per enabled cycle, LSB first, with a serial-valid qualifier and an end-of-word pulse. It is the transmit end of the team's parallel register family and feeds a serial sink, e.g. a SIPO receiver that reassembles the word. One clock domain; synchronous active-high reset.

## Interface
- `N`, 4, data word width; legal range N ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous reset, active-high.
- `load_valid` in 1: producer offers `load_data`.
- `load_data` in N: parallel word, sampled on handshake.
- `shift_en` in 1: sink consumes the current serial bit this cycle.
- `load_ready` out 1: block accepts a word this cycle.
- `sout` out 1: current serial bit.
- `sout_valid` out 1: `sout` carries a valid bit.
- `busy` out 1: a word is in flight.
- `done` out 1: one-cycle pulse when the last bit of a word has been consumed.

## Operation
- FSM states: IDLE, SHIFT. Reset → IDLE.
- IDLE: `load_ready`=1, `sout_valid`=0, `sout`=0, `busy`=0. A handshake (`load_valid` & `load_ready`) at an edge loads the shift register with `load_data`, clears the bit counter, and enters SHIFT. `load_valid` without ready has no effect.
- SHIFT: `load_ready`=0, `busy`=1, `sout_valid`=1, `sout` = shift_reg[0]. On an edge with `shift_en`=1: shift right by one (zero fill) and increment the counter. On the edge consuming the last bit (counter = BITS−1): go to IDLE and assert `done` for the following cycle.
- `shift_en`=0 in SHIFT: register, counter, and `sout` hold.
- `shift_en` in IDLE is ignored.
- BITS = N without parity, N+1 with parity (see Configuration). The counter width is $clog2(BITS+1).
- `load_data` changes outside a handshake never affect an in-flight word.

## Timing
- Reset values, visible the cycle after any edge with `rst`=1: `sout`=0, `sout_valid`=0, `busy`=0, `done`=0. `load_ready`=0 while `rst` is high, and 1 from the first cycle after release.
- Load-to-first-bit latency: 1 cycle. `sout`/`sout_valid` are valid the cycle after the handshake edge.
- Word duration: BITS enabled cycles. With `shift_en` held high, the word occupies exactly BITS cycles of `sout_valid`.
- `done` and `load_ready` rise in the same cycle, the first IDLE cycle. The minimum gap between words is one cycle with `sout_valid`=0.
- Reset mid-word aborts the word: no `done`, the remaining bits are discarded, and the block returns to IDLE.
- `rst` and a handshake on the same edge: reset wins and the word is dropped.
- All outputs are registered or decoded from registered state only. There are no combinational input-to-output paths.

## Configuration
- Macro `PISO_PARITY_EN`.
- Defined: after the N data bits, one extra serial bit equal to the even parity of the loaded word (^load_data) is transmitted. It is captured at load time and BITS = N+1.
- Undefined: no parity bit, BITS = N, and no parity register is present.

## Structure
- Package `piso_pkg`:
  - state enum typedef (IDLE, SHIFT);
  - default width constant;
  - function returning BITS for a given N and the parity setting.
- Sub-module `piso_bit_counter`: synchronous clear and enable-increment counter with a `last` flag (count = BITS−1). It uses the same clk/rst.
- Top level holds the FSM, shift register, and optional parity register.

## Test plan
- Reset then N=4, load 4'b1011, `shift_en`=1 → `sout` = 1,1,0,1 on cycles 1–4 after the handshake, `sout_valid` high for exactly 4 cycles, `done` on cycle 5 with `load_ready`=1.
- Same word with `shift_en`=0 on cycles 2–3 → bit 1 held for 3 cycles, `done` delayed by 2 cycles, and the sequence is unchanged.
- `load_valid` held high with words 4'hA then 4'h5 → the second word is accepted only in the IDLE cycle after `done`; outputs 0,1,0,1 then 1,0,1,0.
- `rst` asserted on the 3rd serial bit → the next cycle shows `sout_valid`=0 and `busy`=0; no `done` occurs; `load_ready`=1 after release.
- `PISO_PARITY_EN` defined, load 4'b1011 → 5 bits 1,1,0,1,1 are sent and `done` follows the 5th bit. Load 4'b0011 → the parity bit is 0.
- Handshake on the same edge as `rst` → no word is transmitted and `sout_valid` stays 0.
